// File: rtl/debounce_pkg.sv
// Shared types and constants for the push-button debouncer.
// The default stability window is 20 ms of samples at a 12 MHz clock.
package debounce_pkg;

  typedef enum logic [1:0] {
    ST_RELEASED     = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } state_t;

  localparam int CNT_MAX_DEFAULT = 240000;

endpackage : debounce_pkg

// File: rtl/debounce_if.sv
// Bundles the debouncer's button-side and pulse-side signals.
// key is a level (no handshake): the master drives it and the debouncer answers with one-cycle key_pulse events.
interface debounce_if;
  import debounce_pkg::*;

  logic   key;
  logic   key_pulse;
  state_t dbg_state;

  modport master (
    output key,
    input  key_pulse,
    input  dbg_state
  );

  modport slave (
    input  key,
    output key_pulse,
    output dbg_state
  );

endinterface : debounce_if

// File: rtl/debounce_sync.sv
// Two-flop synchronizer for the raw button input.
// Resets to 1, the released level, so reset never looks like a press.
module debounce_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_key,
  output logic o_key_sync
);

  logic r_sync1;
  logic r_sync2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_key;
      r_sync2 <= r_sync1;
    end
  end

  assign o_key_sync = r_sync2;

endmodule : debounce_sync

// File: rtl/debounce.sv
// Active-low push-button debouncer: accepts a level change only after CNT_MAX consecutive
// equal synchronized samples and emits one registered pulse per accepted press.
module debounce
  import debounce_pkg::*;
#(
  parameter int CNT_MAX = CNT_MAX_DEFAULT
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   key,
  output logic   key_pulse,
  output state_t o_dbg_state
);

  localparam int             CW       = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);
  localparam bit             SINGLE   = (CNT_MAX == 1);

  logic          w_sync2;
  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_pulse;
  logic          w_pulse_nxt;

  debounce_sync u_sync (
    .clk        (clk),
    .rst        (rst),
    .i_key      (key),
    .o_key_sync (w_sync2)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_RELEASED;
      r_cnt   <= '0;
      r_pulse <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pulse <= w_pulse_nxt;
    end
  end

  // The first differing sample counts as 1, so the wait states finish on CNT_LAST.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pulse_nxt = 1'b0;
    unique case (r_state)
      ST_RELEASED: begin
        w_cnt_nxt = '0;
        if (!w_sync2) begin
          if (SINGLE) begin
            w_state_nxt = ST_PRESSED;
            w_pulse_nxt = 1'b1;
          end else begin
            w_state_nxt = ST_PRESS_WAIT;
            w_cnt_nxt   = CNT_ONE;
          end
        end
      end
      ST_PRESS_WAIT: begin
        if (w_sync2) begin
          w_state_nxt = ST_RELEASED;
          w_cnt_nxt   = '0;
        end else if (r_cnt >= CNT_LAST) begin
          w_state_nxt = ST_PRESSED;
          w_cnt_nxt   = '0;
          w_pulse_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      ST_PRESSED: begin
        w_cnt_nxt = '0;
        if (w_sync2) begin
          if (SINGLE) begin
            w_state_nxt = ST_RELEASED;
          end else begin
            w_state_nxt = ST_RELEASE_WAIT;
            w_cnt_nxt   = CNT_ONE;
          end
        end
      end
      ST_RELEASE_WAIT: begin
        if (!w_sync2) begin
          w_state_nxt = ST_PRESSED;
          w_cnt_nxt   = '0;
        end else if (r_cnt >= CNT_LAST) begin
          w_state_nxt = ST_RELEASED;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = ST_RELEASED;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign key_pulse   = r_pulse;
  assign o_dbg_state = r_state;

  a_cnt_bound: assert property (@(posedge clk) disable iff (rst) r_cnt <= CNT_LAST);

endmodule : debounce

// File: tb/tb_debounce.sv
// Bench for debounce with CNT_MAX=4: directed button scenarios plus random key traffic,
// all checked every cycle against a sliding-window model of the accepted button level.
module tb_debounce;
  import debounce_pkg::*;

  localparam int CNT_MAX = 4;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  debounce_if dif ();

  debounce #(.CNT_MAX(CNT_MAX)) dut (
    .clk         (clk),
    .rst         (rst),
    .key         (dif.key),
    .key_pulse   (dif.key_pulse),
    .o_dbg_state (dif.dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // reference model: two-stage delay, then a level flips when the last
  // CNT_MAX delayed samples all disagree with the currently accepted level
  logic     m_p1;
  logic     m_p2;
  logic     m_level;
  logic     m_win[$];
  logic [0:0] exp_q[$];

  task automatic model_edge(input logic k, input logic r);
    logic exp_pulse;
    bit   all_diff;
    exp_pulse = 1'b0;
    if (r) begin
      m_p1    = 1'b1;
      m_p2    = 1'b1;
      m_level = 1'b1;
      m_win.delete();
    end else begin
      m_win.push_back(m_p2);
      if (m_win.size() > CNT_MAX) void'(m_win.pop_front());
      all_diff = (m_win.size() == CNT_MAX);
      foreach (m_win[i]) if (m_win[i] == m_level) all_diff = 1'b0;
      if (all_diff) begin
        m_level   = ~m_level;
        exp_pulse = (m_level == 1'b0);
        m_win.delete();
      end
      m_p2 = m_p1;
      m_p1 = k;
    end
    exp_q.push_back(exp_pulse);
  endtask

  // scoreboard
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  int edge_idx;
  int n_pulse;
  int first_pulse;

  task automatic mark();
    edge_idx    = 0;
    n_pulse     = 0;
    first_pulse = -1;
  endtask

  // driver: one clock edge with the given key/rst levels
  task automatic step(input logic k, input logic r);
    logic [0:0] exp;
    dif.key = k;
    rst     = r;
    @(posedge clk);
    model_edge(k, r);
    #1;
    exp = exp_q.pop_front();
    check("pulse", 32'(dif.key_pulse), 32'(exp));
    if (dif.key_pulse === 1'b1) begin
      if (first_pulse < 0) first_pulse = edge_idx;
      n_pulse++;
    end
    edge_idx++;
  endtask

  task automatic repeat_step(input logic k, input int n);
    for (int i = 0; i < n; i++) step(k, 1'b0);
  endtask

  logic [5:0] bounce_pat;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    m_p1 = 1'b1; m_p2 = 1'b1; m_level = 1'b1;
    dif.key = 1'b1;
    rst     = 1'b1;
    mark();

    // clean press after a two-cycle reset
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    check("rst_state", 32'(dif.dbg_state), 32'(ST_RELEASED));
    check("rst_pulse", 32'(dif.key_pulse), 32'd0);
    mark();
    repeat_step(1'b0, 56);
    check("clean_cnt", 32'(n_pulse), 32'd1);
    check("clean_at", 32'(first_pulse), 32'd5);
    check("held_state", 32'(dif.dbg_state), 32'(ST_PRESSED));

    // bounce 0,0,1,0,0,1 then stable low
    step(1'b1, 1'b1);
    repeat_step(1'b1, 3);
    mark();
    bounce_pat = 6'b100100;
    for (int i = 0; i < 6; i++) step(bounce_pat[i], 1'b0);
    repeat_step(1'b0, 20);
    check("bounce_cnt", 32'(n_pulse), 32'd1);
    check("bounce_at", 32'(first_pulse), 32'd11);

    // short low glitch
    step(1'b1, 1'b1);
    repeat_step(1'b1, 2);
    mark();
    repeat_step(1'b0, 3);
    repeat_step(1'b1, 20);
    check("glitch_cnt", 32'(n_pulse), 32'd0);
    check("glitch_state", 32'(dif.dbg_state), 32'(ST_RELEASED));

    // press, short release, re-press, long release, press again
    step(1'b1, 1'b1);
    repeat_step(1'b1, 2);
    mark();
    repeat_step(1'b0, 10);
    check("press1_at", 32'(first_pulse), 32'd5);
    repeat_step(1'b1, 2);
    repeat_step(1'b0, 10);
    check("repress_cnt", 32'(n_pulse), 32'd1);
    repeat_step(1'b1, 10);
    check("release_cnt", 32'(n_pulse), 32'd1);
    mark();
    repeat_step(1'b0, 12);
    check("press2_cnt", 32'(n_pulse), 32'd1);
    check("press2_at", 32'(first_pulse), 32'd5);

    // reset while a press is being counted
    step(1'b1, 1'b1);
    repeat_step(1'b1, 2);
    mark();
    repeat_step(1'b0, 3);
    step(1'b0, 1'b1);
    check("midrst_pre", 32'(n_pulse), 32'd0);
    check("midrst_state", 32'(dif.dbg_state), 32'(ST_RELEASED));
    mark();
    repeat_step(1'b0, 12);
    check("midrst_cnt", 32'(n_pulse), 32'd1);
    check("midrst_at", 32'(first_pulse), 32'd5);

    // reset landing on the edge where the pulse would rise
    step(1'b1, 1'b1);
    repeat_step(1'b1, 2);
    mark();
    repeat_step(1'b0, 5);
    step(1'b0, 1'b1);
    check("edge_rst_cnt", 32'(n_pulse), 32'd0);

    // random key traffic with occasional resets
    for (int r = 0; r < 400; r++) begin
      logic lvl;
      int   len;
      lvl = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 8));
      if ($urandom_range(0, 29) == 0) step(lvl, 1'b1);
      repeat_step(lvl, len);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_debounce

// File: doc/debounce.md
DEBOUNCE -- requirements
Module: debounce

Interface
REQ-001 SHALL have parameter CNT_MAX, default 240000, meaning the number of consecutive stable synchronized samples needed to accept a level change (20 ms at 12 MHz); legal range >= 1.
REQ-002 SHALL have port clk  input  1  system clock; all logic is on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port key  input  1  raw asynchronous push-button, active-low (0 = pressed, 1 = released).
REQ-005 SHALL have port key_pulse  output  1  registered; high for exactly one clk cycle per accepted press.

Function
REQ-006 SHALL pass key through a 2-flop synchronizer (sync1, then sync2); only sync2 feeds the FSM.
REQ-007 SHALL implement a 4-state FSM: RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT, with a stability counter cnt of width clog2(CNT_MAX+1).
REQ-008 RELEASED: sync2=0 -> PRESS_WAIT with cnt<=1; otherwise stay, with cnt<=0.
REQ-009 PRESS_WAIT: sync2=1 -> RELEASED with cnt<=0 (bounce rejected); sync2=0 and cnt<CNT_MAX-1 -> cnt<=cnt+1; sync2=0 and cnt=CNT_MAX-1 -> PRESSED with cnt<=0 and key_pulse<=1.
REQ-010 PRESSED: sync2=1 -> RELEASE_WAIT with cnt<=1; otherwise stay.
REQ-011 RELEASE_WAIT: sync2=0 -> PRESSED with cnt<=0 and no pulse; sync2=1 and cnt=CNT_MAX-1 -> RELEASED with cnt<=0; otherwise cnt<=cnt+1.
REQ-012 If CNT_MAX=1, SHALL accept a press on the first cycle sync2=0 is seen in RELEASED (direct RELEASED -> PRESSED with pulse), and a release on the first cycle sync2=1 is seen in PRESSED (direct PRESSED -> RELEASED).
REQ-013 key_pulse SHALL default to 0 in every cycle where REQ-009 or REQ-012 does not assert it; no pulse SHALL occur on release.
REQ-014 Latency SHALL be as follows: with key held low from rising edge E0 on (first edge sampling it low), key_pulse is set at edge E(CNT_MAX+1) and cleared at E(CNT_MAX+2).
REQ-015 Any low glitch shorter than CNT_MAX synchronized samples SHALL produce no pulse; any high glitch shorter than CNT_MAX samples while held SHALL produce no second pulse.
REQ-016 Holding key low indefinitely SHALL produce exactly one pulse (no auto-repeat).
REQ-017 The counter SHALL never exceed CNT_MAX-1 and SHALL never wrap.

Reset
REQ-018 While rst=1 at a rising edge, the block SHALL set sync1=1, sync2=1, state=RELEASED, cnt=0 and key_pulse=0.
REQ-019 Reset asserted mid-operation, including the cycle key_pulse would rise, SHALL suppress the pulse and abort any pending count.
REQ-020 If key is held low across reset release, the block SHALL treat it as a new press and pulse after the REQ-014 latency.

Structure
REQ-021 Package debounce_pkg SHALL hold the FSM state enum and the default CNT_MAX constant.
REQ-022 The synchronizer SHALL be the single sub-module debounce_sync (2 flops, reset value 1); the FSM, counter and output register SHALL stay in debounce.
REQ-023 The block SHALL contain no latches and no combinational path from key to key_pulse.

Verification (bench uses CNT_MAX=4)
REQ-024 Clean press: rst for 2 cycles, then key=0 held -> key_pulse=1 for exactly one cycle at E5 (6th edge sampling low); no further pulse over 50 cycles.
REQ-025 Bounce: key pattern 0,0,1,0,0,1 (one value per cycle), then stable 0 -> single pulse 6 edges after the start of the stable-0 run.
REQ-026 Short glitch: key=0 for 3 cycles, then 1 -> key_pulse stays 0 throughout.
REQ-027 Release and re-press: press (pulse), release for 2 cycles, then low again -> no second pulse; release for 10 cycles, then press -> second pulse with REQ-014 latency.
REQ-028 Reset mid-count: key=0, then rst=1 at E3 for one cycle with key still low -> no pulse before reset; one pulse 6 edges after the first post-reset edge.
